crypto_req_sequencer: RTL

Upstream command stage for crypto_coproc. It accepts encrypt/decrypt requests from the CPU over a valid/ready interface and buffers them in a small FIFO. It issues each request to crypto_coproc by driving data_in and exactly one of enc/dec, waits for result_ready, captures data_out, and returns it on a valid/ready response interface. A timeout guards against a stalled coprocessor.

---
 rtl/crypto_seq_pkg.sv | 15 +
 rtl/crypto_req_fifo.sv | 46 ++++
 rtl/crypto_req_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/crypto_seq_pkg.sv
// Shared types and constants for the crypto request sequencer.
package crypto_seq_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/crypto_req_fifo.sv
// Synchronous request FIFO of {op, data}; pointers carry an extra wrap bit
// so full and empty are distinguishable.
module crypto_req_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/crypto_req_sequencer.sv
// Command sequencer in front of crypto_coproc: buffers requests, issues one at a
// time, collects the result or times out. Optional CRYPTO_SEQ_IDLE_ZERO_EN zeroes idle data.
module crypto_req_sequencer
    import crypto_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_op,
    output logic              rsp_err,
    output logic [DATA_W-1:0] cp_data_in,
    output logic              cp_enc,
    output logic              cp_dec,
    input  logic [DATA_W-1:0] cp_data_out,
    input  logic              cp_result_ready,
    output logic              busy
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    seq_state_t        state, state_d;
    logic [7:0]        cnt, cnt_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              head_ready_q;
    logic [DATA_W:0]   head;
    logic [DATA_W-1:0] cp_data_in_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic              cp_enc_d, cp_dec_d;
    logic              rsp_op_d, rsp_err_d, rsp_valid_d;

    crypto_req_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .wdata ({req_op, req_data}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    // A freshly written head is only issued once it has been visible for a full
    // cycle, giving two edges from push to cp_enc/cp_dec.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) head_ready_q <= 1'b0;
        else     head_ready_q <= !fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cp_data_in <= '0;
            cp_enc     <= 1'b0;
            cp_dec     <= 1'b0;
            rsp_data   <= '0;
            rsp_op     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cp_data_in <= cp_data_in_d;
            cp_enc     <= cp_enc_d;
            cp_dec     <= cp_dec_d;
            rsp_data   <= rsp_data_d;
            rsp_op     <= rsp_op_d;
            rsp_err    <= rsp_err_d;
            rsp_valid  <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        fifo_pop     = 1'b0;
        cp_data_in_d = cp_data_in;
        cp_enc_d     = cp_enc;
        cp_dec_d     = cp_dec;
        rsp_data_d   = rsp_data;
        rsp_op_d     = rsp_op;
        rsp_err_d    = rsp_err;
        rsp_valid_d  = rsp_valid;

        case (state)
            IDLE: begin
                if (head_ready_q && !fifo_empty) begin
                    fifo_pop     = 1'b1;
                    cp_data_in_d = head[DATA_W-1:0];
                    cp_dec_d     = (head[DATA_W] == OP_DEC);
                    cp_enc_d     = (head[DATA_W] != OP_DEC);
                    cnt_d        = 8'd1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if ((cp_result_ready && cnt >= 8'd1) || cnt == TIMEOUT_C) begin
                    // The op is recovered from cp_dec, which is held for the whole command.
                    rsp_op_d    = cp_dec;
                    rsp_err_d   = !cp_result_ready;
                    rsp_data_d  = cp_result_ready ? cp_data_out : '0;
                    rsp_valid_d = 1'b1;
                    cp_enc_d    = 1'b0;
                    cp_dec_d    = 1'b0;
`ifdef CRYPTO_SEQ_IDLE_ZERO_EN
                    cp_data_in_d = '0;
`endif
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
`ifdef CRYPTO_SEQ_IDLE_ZERO_EN
                    rsp_data_d  = '0;
`endif
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
